// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: two-requester (core, dbg) read-modify-write CSR access arbiter.
// Define CSR_ARBITER_ROUND_ROBIN_EN for round-robin grants; default is fixed core priority.
// Ports: clk, reset_n (async, active-low);
//   core_* / dbg_* : req, op, index, wdata in; ack, err, rdata out;
//   csr_read_*  : enable, index out; data in (same cycle);
//   csr_write_* : enable, index, data out;
//   busy        : high whenever not idle.
module csr_access_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic [1:0]  core_op,
  input  logic [11:0] core_index,
  input  logic [31:0] core_wdata,
  output logic        core_ack,
  output logic        core_err,
  output logic [31:0] core_rdata,
  input  logic        dbg_req,
  input  logic [1:0]  dbg_op,
  input  logic [11:0] dbg_index,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic        csr_read_enable,
  output logic [11:0] csr_read_index,
  input  logic [31:0] csr_read_data,
  output logic        csr_write_enable,
  output logic [11:0] csr_write_index,
  output logic [31:0] csr_write_data,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        gnt_dbg;
  logic        gnt_dbg_q;
  logic [1:0]  op_q;
  logic [11:0] index_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic        err_q;
  logic        need_write;
  logic        read_only;
  logic        grant;
  logic [31:0] new_value;
  logic [31:0] resp_value;

  assign grant = (state_q == IDLE) & (core_req | dbg_req);

`ifdef CSR_ARBITER_ROUND_ROBIN_EN
  // prio_dbg_q set means dbg lost (or never won) the last grant.
  logic prio_dbg_q;

  assign gnt_dbg = dbg_req & (~core_req | prio_dbg_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_dbg_q <= 1'b0;
    end else if (grant) begin
      prio_dbg_q <= ~gnt_dbg;
    end
  end
`else
  assign gnt_dbg = dbg_req & ~core_req;
`endif

  // RS/RC with a zero operand leave the CSR untouched.
  assign need_write = (op_q == OP_RW) | (op_q[1] & (|wdata_q));
  assign read_only  = &index_q[11:10];

  always_comb begin
    new_value = old_q;
    unique case (op_q)
      OP_RW:   new_value = wdata_q;
      OP_RS:   new_value = old_q | wdata_q;
      OP_RC:   new_value = old_q & ~wdata_q;
      default: new_value = old_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (core_req | dbg_req) state_d = READ;
      READ:    state_d = (need_write & ~read_only) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_dbg_q <= 1'b0;
      op_q      <= 2'd0;
      index_q   <= 12'd0;
      wdata_q   <= 32'd0;
      old_q     <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_dbg_q <= gnt_dbg;
        op_q      <= gnt_dbg ? dbg_op    : core_op;
        index_q   <= gnt_dbg ? dbg_index : core_index;
        wdata_q   <= gnt_dbg ? dbg_wdata : core_wdata;
        err_q     <= 1'b0;
      end
      if (state_q == READ) begin
        old_q <= csr_read_data;
        err_q <= need_write & read_only;
      end
    end
  end

  // Coming straight from READ the old value is still on the read port.
  assign resp_value = (state_q == READ) ? csr_read_data : old_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_rdata <= 32'd0;
      dbg_rdata  <= 32'd0;
    end else if (state_d == RESP && state_q != RESP) begin
      if (gnt_dbg_q) dbg_rdata  <= resp_value;
      else           core_rdata <= resp_value;
    end
  end

  assign core_ack = (state_q == RESP) & ~gnt_dbg_q;
  assign dbg_ack  = (state_q == RESP) &  gnt_dbg_q;
  assign core_err = core_ack & err_q;
  assign dbg_err  = dbg_ack & err_q;

  assign csr_read_enable  = (state_q == READ);
  assign csr_read_index   = csr_read_enable ? index_q : 12'd0;
  assign csr_write_enable = (state_q == WRITE);
  assign csr_write_index  = csr_write_enable ? index_q : 12'd0;
  assign csr_write_data   = csr_write_enable ? new_value : 32'd0;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_csr_access_arbiter.sv
// tb_csr_access_arbiter: randomized + directed bench for csr_access_arbiter.
// A transaction-level model predicts every output each cycle.
module tb_csr_access_arbiter;

`ifdef CSR_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_req = 1'b0;
  logic [1:0]  core_op = 2'd0;
  logic [11:0] core_index = 12'd0;
  logic [31:0] core_wdata = 32'd0;
  logic        core_ack, core_err;
  logic [31:0] core_rdata;
  logic        dbg_req = 1'b0;
  logic [1:0]  dbg_op = 2'd0;
  logic [11:0] dbg_index = 12'd0;
  logic [31:0] dbg_wdata = 32'd0;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic        csr_read_enable;
  logic [11:0] csr_read_index;
  logic [31:0] csr_read_data;
  logic        csr_write_enable;
  logic [11:0] csr_write_index;
  logic [31:0] csr_write_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_access_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_op(core_op),
    .core_index(core_index), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_op(dbg_op),
    .dbg_index(dbg_index), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .csr_read_enable(csr_read_enable), .csr_read_index(csr_read_index),
    .csr_read_data(csr_read_data),
    .csr_write_enable(csr_write_enable), .csr_write_index(csr_write_index),
    .csr_write_data(csr_write_data),
    .busy(busy)
  );

  function automatic logic [31:0] seed_val(input int i);
    return (32'(i) * 32'h0101_0011) ^ 32'h3C5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // CSR register file environment
  logic [31:0] mem [4096];
  bit mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed_val(i);
      mem_ready <= 1'b1;
    end else if (csr_write_enable) begin
      mem[csr_write_index] <= csr_write_data;
    end
  end

  assign csr_read_data = csr_read_enable ? mem[csr_read_index] : 32'hDEAD_BEEF;

  // Transaction-level reference model
  logic [31:0] mmem [4096];
  bit          m_ready = 1'b0;
  int          ph = 0;
  int          t_len = 0;
  bit          t_dbg, t_w, t_err;
  logic [11:0] t_idx;
  logic [31:0] t_old, t_new;
  logic [31:0] e_crd = 32'd0;
  logic [31:0] e_drd = 32'd0;
  bit          m_last_dbg = 1'b1;

  always @(negedge clk) begin : model
    bit          e_ren, e_wen, e_ca, e_ce, e_da, e_de, e_busy;
    logic [11:0] e_ri, e_wi;
    logic [31:0] e_wd, wd;
    logic [1:0]  op;
    bit          g, nw, ro;
    if (!m_ready) begin
      for (int i = 0; i < 4096; i++) mmem[i] = seed_val(i);
      m_ready = 1'b1;
    end
    e_ren = 0; e_wen = 0; e_ca = 0; e_ce = 0;
    e_da = 0; e_de = 0; e_busy = 0;
    e_ri = '0; e_wi = '0; e_wd = '0;
    if (!reset_n) begin
      ph = 0; e_crd = '0; e_drd = '0; m_last_dbg = 1'b1;
    end else if (ph != 0) begin
      e_busy = 1;
      if (ph == 1) begin e_ren = 1; e_ri = t_idx; end
      if (ph == 2 && t_w) begin
        e_wen = 1; e_wi = t_idx; e_wd = t_new;
      end
      if (ph == t_len) begin
        if (t_dbg) begin e_da = 1; e_de = t_err; e_drd = t_old; end
        else begin e_ca = 1; e_ce = t_err; e_crd = t_old; end
        if (t_w) mmem[t_idx] = t_new;
      end
    end
    chk("busy", busy, e_busy);
    chk("rd_en", csr_read_enable, e_ren);
    chk("rd_idx", csr_read_index, e_ri);
    chk("wr_en", csr_write_enable, e_wen);
    chk("wr_idx", csr_write_index, e_wi);
    chk("wr_data", csr_write_data, e_wd);
    chk("core_ack", core_ack, e_ca);
    chk("core_err", core_err, e_ce);
    chk("core_rdata", core_rdata, e_crd);
    chk("dbg_ack", dbg_ack, e_da);
    chk("dbg_err", dbg_err, e_de);
    chk("dbg_rdata", dbg_rdata, e_drd);
    if (reset_n) begin
      if (ph != 0) begin
        ph = (ph == t_len) ? 0 : ph + 1;
      end else if (core_req || dbg_req) begin
        g = dbg_req && (!core_req || (RR && !m_last_dbg));
        m_last_dbg = g;
        t_dbg = g;
        t_idx = g ? dbg_index : core_index;
        op    = g ? dbg_op : core_op;
        wd    = g ? dbg_wdata : core_wdata;
        t_old = mmem[t_idx];
        nw    = (op == 2'd1) || (op >= 2'd2 && wd != 0);
        ro    = (t_idx[11:10] == 2'b11);
        t_err = nw && ro;
        t_w   = nw && !ro;
        case (op)
          2'd1:    t_new = wd;
          2'd2:    t_new = t_old | wd;
          2'd3:    t_new = t_old & ~wd;
          default: t_new = t_old;
        endcase
        t_len = t_w ? 3 : 2;
        ph = 1;
      end
    end
  end

  logic [11:0] idx_tab [8] = '{12'h800, 12'h801, 12'h810, 12'h820,
                               12'hB00, 12'hC00, 12'hC01, 12'h300};

  task automatic rnd(output logic [1:0] op, output logic [11:0] idx,
                     output logic [31:0] wd);
    op  = 2'($urandom_range(0, 3));
    idx = idx_tab[$urandom_range(0, 7)];
    wd  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
  endtask

  task automatic run_one(input bit d, input logic [1:0] op,
                         input logic [11:0] idx, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd,
                         output bit er, output int nwr,
                         output logic [31:0] wdat, output logic [11:0] widx);
    bit done;
    done = 0; lat = 0; nwr = 0; rd = '0; er = 0; wdat = '0; widx = '0;
    @(posedge clk); #1;
    if (d) begin
      dbg_req = 1; dbg_op = op; dbg_index = idx; dbg_wdata = wd;
    end else begin
      core_req = 1; core_op = op; core_index = idx; core_wdata = wd;
    end
    @(posedge clk);
    for (int c = 1; c <= 10 && !done; c++) begin
      @(negedge clk);
      if (csr_write_enable) begin
        nwr++; wdat = csr_write_data; widx = csr_write_index;
      end
      if (d ? dbg_ack : core_ack) begin
        lat = c;
        rd  = d ? dbg_rdata : core_rdata;
        er  = d ? dbg_err : core_err;
        done = 1;
      end
    end
    chk("ack_timeout", done, 1);
    @(posedge clk); #1;
    core_req = 0; dbg_req = 0;
  endtask

  initial begin
    int          lat, nwr, n, cnt;
    logic [31:0] rd, wdat;
    logic [11:0] widx;
    bit          er, seen, ca, da;
    int          who [4];

    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {core_ack, dbg_ack, core_err, dbg_err, busy,
                     csr_read_enable, csr_write_enable}, 0);
    chk("rst_rdata", {core_rdata, dbg_rdata}, 0);
    reset_n = 1;

    // core RW 0x800 0xA5 over old 0
    run_one(0, 2'd1, 12'h800, 32'h0, lat, rd, er, nwr, wdat, widx);
    run_one(0, 2'd1, 12'h800, 32'hA5, lat, rd, er, nwr, wdat, widx);
    chk("rw_lat", lat, 3);
    chk("rw_rdata", rd, 32'h0);
    chk("rw_err", er, 0);
    chk("rw_nwr", nwr, 1);
    chk("rw_widx", widx, 12'h800);
    chk("rw_wdata", wdat, 32'hA5);

    // dbg RS 0 over 0x12
    run_one(1, 2'd1, 12'h810, 32'h12, lat, rd, er, nwr, wdat, widx);
    run_one(1, 2'd2, 12'h810, 32'h0, lat, rd, er, nwr, wdat, widx);
    chk("rs0_lat", lat, 2);
    chk("rs0_rdata", rd, 32'h12);
    chk("rs0_err", er, 0);
    chk("rs0_nwr", nwr, 0);

    // core RC 0x0F over 0xFF
    run_one(0, 2'd1, 12'h820, 32'hFF, lat, rd, er, nwr, wdat, widx);
    run_one(0, 2'd3, 12'h820, 32'h0F, lat, rd, er, nwr, wdat, widx);
    chk("rc_lat", lat, 3);
    chk("rc_rdata", rd, 32'hFF);
    chk("rc_wdata", wdat, 32'hF0);
    run_one(0, 2'd0, 12'h820, 32'h0, lat, rd, er, nwr, wdat, widx);
    chk("rd_lat", lat, 2);
    chk("rd_after_rc", rd, 32'hF0);

    // read-only space
    run_one(0, 2'd1, 12'hC00, 32'h1234, lat, rd, er, nwr, wdat, widx);
    chk("ro_lat", lat, 2);
    chk("ro_err", er, 1);
    chk("ro_nwr", nwr, 0);
    chk("ro_rdata", rd, seed_val(12'hC00));
    run_one(0, 2'd0, 12'hC00, 32'h0, lat, rd, er, nwr, wdat, widx);
    chk("ro_read_err", er, 0);
    chk("ro_read_rdata", rd, seed_val(12'hC00));
    run_one(0, 2'd2, 12'hC01, 32'h0, lat, rd, er, nwr, wdat, widx);
    chk("ro_rs0_err", er, 0);
    chk("ro_rs0_lat", lat, 2);

    // both requesters held for 4 grants
    @(posedge clk); #1;
    core_req = 1; core_op = 2'd0; core_index = 12'h300; core_wdata = 0;
    dbg_req = 1; dbg_op = 2'd0; dbg_index = 12'h301; dbg_wdata = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (core_ack) begin who[n] = 0; n++; end
      else if (dbg_ack) begin who[n] = 1; n++; end
    end
    @(posedge clk); #1;
    core_req = 0; dbg_req = 0;
    chk("arb_count", n, 4);
    for (int k = 0; k < 4; k++)
      chk("arb_grant", who[k], RR ? (k % 2) : 0);

    // reset during WRITE
    @(posedge clk); #1;
    core_req = 1; core_op = 2'd1; core_index = 12'h801; core_wdata = 32'h55;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (csr_write_enable) seen = 1;
    end
    chk("rst_write_seen", seen, 1);
    #1;
    reset_n = 0; core_req = 0;
    #1;
    chk("rst_mid_outs", {core_ack, core_err, dbg_ack, dbg_err, busy,
                         csr_read_enable, csr_write_enable,
                         csr_read_index, csr_write_index}, 0);
    chk("rst_mid_wdata", csr_write_data, 0);
    chk("rst_mid_rdata", {core_rdata, dbg_rdata}, 0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (core_ack || dbg_ack || csr_write_enable) cnt++;
    end
    chk("rst_no_ack", cnt, 0);
    chk("rst_no_write", mem[12'h801], seed_val(12'h801));
    run_one(0, 2'd0, 12'hB00, 32'h0, lat, rd, er, nwr, wdat, widx);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_rdata", rd, seed_val(12'hB00));
    chk("post_rst_err", er, 0);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      ca = core_ack; da = dbg_ack;
      @(posedge clk); #1;
      if (core_req) begin
        if (ca) begin
          if ($urandom_range(0, 2) == 0) rnd(core_op, core_index, core_wdata);
          else core_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        rnd(core_op, core_index, core_wdata);
        core_req = 1;
      end
      if (dbg_req) begin
        if (da) begin
          if ($urandom_range(0, 2) == 0) rnd(dbg_op, dbg_index, dbg_wdata);
          else dbg_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        rnd(dbg_op, dbg_index, dbg_wdata);
        dbg_req = 1;
      end
    end
    core_req = 0; dbg_req = 0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_access_arbiter.md
CSR_ACCESS_ARBITER -- requirements
Module: csr_access_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 core_req, core_op, core_index, core_wdata  input  1/2/12/32  pipeline CSR request: valid, op (00 read, 01 RW, 10 RS, 11 RC), CSR index, operand.
REQ-005 core_ack, core_err, core_rdata  output  1/1/32  one-cycle completion pulse, error flag, old CSR value.
REQ-006 dbg_req, dbg_op, dbg_index, dbg_wdata  input  1/2/12/32  configuration/debug requester; encoding as REQ-004.
REQ-007 dbg_ack, dbg_err, dbg_rdata  output  1/1/32  as REQ-005 for the debug requester.
REQ-008 csr_read_enable, csr_read_index  output  1/12  read port drive toward CSR register file.
REQ-009 csr_read_data  input  32  CSR file read value, valid in the same cycle as csr_read_enable.
REQ-010 csr_write_enable, csr_write_index, csr_write_data  output  1/12/32  write port drive toward CSR register file.
REQ-011 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, READ, WRITE, RESP; the encoding is free.
REQ-013 IDLE: if any req is high, the block SHALL grant one requester, latch its op/index/wdata, and go to READ; otherwise it stays in IDLE.
REQ-014 READ: the block SHALL assert csr_read_enable with the latched index for exactly one cycle and capture csr_read_data as old_value.
REQ-015 Next state after READ SHALL be WRITE if a write is required, else RESP.
REQ-016 A write SHALL be required when op=RW, or when op=RS/RC and wdata is nonzero.
REQ-017 WRITE: the block SHALL pulse csr_write_enable for one cycle with the latched index and new value, then go to RESP.
REQ-018 New value SHALL be: RW wdata; RS old_value OR wdata; RC old_value AND NOT wdata.
REQ-019 If a write is required and index[11:10]=2'b11 (read-only space), the block SHALL skip WRITE and flag err.
REQ-020 RESP: the block SHALL pulse the granted requester's ack for one cycle, drive rdata=old_value and err, then return to IDLE.
REQ-021 Latency SHALL be: grant edge to ack = 3 cycles with a write, 2 cycles without.
REQ-022 Non-granted ack/err SHALL be 0; rdata SHALL hold its last value.
REQ-023 Requesters SHALL keep req high until ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-024 Request inputs SHALL be ignored outside IDLE; latched fields SHALL not change mid-transaction.
REQ-025 All csr_* outputs SHALL be 0 when not in READ or WRITE respectively.

Reset
REQ-026 While reset_n=0, the FSM SHALL be IDLE and all outputs 0, including rdata, err, ack, busy, enables, indices and write data.
REQ-027 If reset occurs mid-transaction, the transaction SHALL be abandoned with no write and no ack issued after release.
REQ-028 The round-robin pointer, when present, SHALL reset to favour core.

Configuration
REQ-029 The macro CSR_ARBITER_ROUND_ROBIN_EN SHALL select the arbitration policy when defined.
REQ-030 When defined, simultaneous requests SHALL be granted to the requester not granted last; the pointer SHALL update on every grant.
REQ-031 When undefined, arbitration SHALL be fixed priority with core always winning, and no pointer state SHALL exist.

Verification
REQ-032 core RW index 0x800 wdata 0x0000_00A5, old 0x0 -> read pulse, write 0xA5 to 0x800, core_ack at +3 cycles with rdata 0x0.
REQ-033 dbg RS wdata 0x0 on a CSR holding 0x12 -> no csr_write_enable; dbg_ack at +2 cycles with rdata 0x12 and err 0.
REQ-034 core RC wdata 0x0F on a CSR holding 0xFF -> write 0xF0; core RW to 0xC00 -> no write, err 1, ack at +2.
REQ-035 core and dbg requests both held high for 4 transactions -> with the macro defined, grants go core, dbg, core, dbg; with it undefined, all 4 go to core.
REQ-036 reset_n low during WRITE -> no ack, all outputs 0; after release, a fresh core read of 0xB00 completes normally.
